// File: rtl/sa_skew_feeder.sv
// Input staging for an NxN systolic PE array.
// Lane r of the A and B operand edges is delayed by r cycles (triangular skew).
// After a tile it flushes zeros through the array.
// It then raises send-data for N cycles to shift the accumulators out.
module sa_skew_feeder #(
    parameter int unsigned N        = 4,
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned K_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [K_WIDTH-1:0]    i_k,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [N*IN_WIDTH-1:0] i_a_vec,
    input  logic [N*IN_WIDTH-1:0] i_b_vec,
    output logic [N*IN_WIDTH-1:0] o_a_edge,
    output logic [N*IN_WIDTH-1:0] o_b_edge,
    output logic                  o_ctrl_sa_send_data,
    output logic                  o_busy,
    output logic                  o_done
);

    // Phase counter must reach 2N-2 (flush) and N-1 (drain).
    localparam int unsigned PW = (N > 1) ? $clog2(2 * N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StDrain
    } state_t;

    state_t             state;
    logic [K_WIDTH-1:0] k_q;
    logic [K_WIDTH-1:0] beat_cnt;
    logic [PW-1:0]      phase;
    logic               done_q;
    logic               hs;

    // Status outputs decode the state register directly; none depend on inputs.
    always_comb begin
        o_ready             = (state == StLoad);
        o_busy              = (state != StIdle);
        o_ctrl_sa_send_data = (state == StDrain);
        o_done              = done_q;
        hs                  = i_valid & (state == StLoad);
    end

    // Tile sequencer: IDLE -> LOAD (k beats) -> FLUSH (2N-1) -> DRAIN (N) -> IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= StIdle;
            k_q      <= '0;
            beat_cnt <= '0;
            phase    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                StIdle: begin
                    // A zero-depth tile is ignored entirely.
                    if (i_start && (i_k != '0)) begin
                        k_q      <= i_k;
                        beat_cnt <= '0;
                        state    <= StLoad;
                    end
                end
                StLoad: begin
                    if (hs) begin
                        if (beat_cnt == k_q - K_WIDTH'(1)) begin
                            state <= StFlush;
                            phase <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + K_WIDTH'(1);
                        end
                    end
                end
                StFlush: begin
                    if (phase == PW'(2 * N - 2)) begin
                        state <= StDrain;
                        phase <= '0;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                StDrain: begin
                    if (phase == PW'(N - 1)) begin
                        state  <= StIdle;
                        done_q <= 1'b1;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Lane r owns an (r+1)-deep shift register for each operand.
    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [IN_WIDTH-1:0] a_sr [r+1];
        logic [IN_WIDTH-1:0] b_sr [r+1];

        // Stage 0 takes lane data on handshake, zero otherwise, so bubbles stay aligned.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int j = 0; j <= r; j++) begin
                    a_sr[j] <= '0;
                    b_sr[j] <= '0;
                end
            end else begin
                a_sr[0] <= hs ? i_a_vec[r*IN_WIDTH +: IN_WIDTH] : '0;
                b_sr[0] <= hs ? i_b_vec[r*IN_WIDTH +: IN_WIDTH] : '0;
                for (int j = 1; j <= r; j++) begin
                    a_sr[j] <= a_sr[j-1];
                    b_sr[j] <= b_sr[j-1];
                end
            end
        end

        assign o_a_edge[r*IN_WIDTH +: IN_WIDTH] = a_sr[r];
        assign o_b_edge[r*IN_WIDTH +: IN_WIDTH] = b_sr[r];
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder with a behavioural 4x4 PE array model.
module tb_sa_skew_feeder;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [KW-1:0]   k = '0;
    logic            valid = 1'b0;
    logic            ready;
    logic [N*W-1:0]  a_vec = '0;
    logic [N*W-1:0]  b_vec = '0;
    logic [N*W-1:0]  a_edge;
    logic [N*W-1:0]  b_edge;
    logic            send;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    sa_skew_feeder #(.N(N), .IN_WIDTH(W), .K_WIDTH(KW)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_start             (start),
        .i_k                 (k),
        .i_valid             (valid),
        .o_ready             (ready),
        .i_a_vec             (a_vec),
        .i_b_vec             (b_vec),
        .o_a_edge            (a_edge),
        .o_b_edge            (b_edge),
        .o_ctrl_sa_send_data (send),
        .o_busy              (busy),
        .o_done              (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
    } stage_t;

    // Scoreboard: stage-0 vector pushed per driven cycle, newest at the back.
    stage_t hist[$];

    logic [W-1:0] beat_a[16][N];
    logic [W-1:0] beat_b[16][N];

    int acc[N][N];
    int ap[N][N];
    int bp[N][N];
    int drained[N][N];
    int n_drained;

    function automatic logic [N*W-1:0] exp_edge(input bit is_b);
        logic [N*W-1:0] v;
        stage_t s;
        v = '0;
        for (int r = 0; r < N; r++) begin
            if (hist.size() > r) begin
                s = hist[hist.size()-1-r];
                v[r*W +: W] = is_b ? s.b[r*W +: W] : s.a[r*W +: W];
            end
        end
        return v;
    endfunction

    // Output-stationary array: a moves right, b moves down, send shifts acc down with zero on top.
    task automatic step_array();
        int na[N][N];
        int nb[N][N];
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                na[r][c] = (c == 0) ? int'(a_edge[r*W +: W]) : ap[r][c-1];
                nb[r][c] = (r == 0) ? int'(b_edge[c*W +: W]) : bp[r-1][c];
            end
        if (send) begin
            for (int c = 0; c < N; c++) begin
                if (n_drained < N) drained[N-1-n_drained][c] = acc[N-1][c];
                for (int r = N - 1; r > 0; r--) acc[r][c] = acc[r-1][c];
                acc[0][c] = 0;
            end
            n_drained++;
        end else begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) acc[r][c] += na[r][c] * nb[r][c];
        end
        ap = na;
        bp = nb;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++)
            for (int r = 0; r < N; r++) begin
                beat_a[i][r] = W'($urandom);
                beat_b[i][r] = W'($urandom);
            end
    endtask

    // Runs one tile from IDLE; start issued in cycle 0. Optional bubbles, restart pulse, reset.
    task automatic run_tile(input string tag, input int kb, input logic [31:0] bubble,
                            input int restart_at, input int rst_at);
        int    beats = 0;
        int    last = -1;
        bit    aborted = 1'b0;
        bit    finished = 1'b0;
        bit    loading, hs_exp;
        bit    e_ready, e_busy, e_send, e_done;
        logic [N*W-1:0] e_a, e_b;
        stage_t s;
        hist.delete();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            start   = (c == 0) || (c == restart_at);
            k       = (c == 0) ? KW'(kb) : KW'(9);
            rst     = (c == rst_at);
            loading = (c >= 1) && (beats < kb) && !aborted;
            valid   = !bubble[c % 32];
            hs_exp  = loading && valid;
            for (int r = 0; r < N; r++) begin
                a_vec[r*W +: W] = hs_exp ? beat_a[beats][r] : W'($urandom);
                b_vec[r*W +: W] = hs_exp ? beat_b[beats][r] : W'($urandom);
            end
            @(negedge clk);
            if (aborted) begin
                e_ready = 0; e_busy = 0; e_send = 0; e_done = 0;
            end else begin
                e_ready = loading;
                e_busy  = (c >= 1) && (last < 0 || c < last + 3 * N);
                e_send  = (last >= 0) && (c >= last + 2 * N) && (c <= last + 3 * N - 1);
                e_done  = (last >= 0) && (c == last + 3 * N);
            end
            e_a = exp_edge(1'b0);
            e_b = exp_edge(1'b1);
            n_cmp += 6;
            if (ready !== e_ready) begin
                n_bad++; $display("FAIL %s ready c=%0d got %b want %b", tag, c, ready, e_ready);
            end
            if (busy !== e_busy) begin
                n_bad++; $display("FAIL %s busy c=%0d got %b want %b", tag, c, busy, e_busy);
            end
            if (send !== e_send) begin
                n_bad++; $display("FAIL %s send c=%0d got %b want %b", tag, c, send, e_send);
            end
            if (done !== e_done) begin
                n_bad++; $display("FAIL %s done c=%0d got %b want %b", tag, c, done, e_done);
            end
            if (a_edge !== e_a) begin
                n_bad++; $display("FAIL %s a_edge c=%0d got %h want %h", tag, c, a_edge, e_a);
            end
            if (b_edge !== e_b) begin
                n_bad++; $display("FAIL %s b_edge c=%0d got %h want %h", tag, c, b_edge, e_b);
            end
            step_array();
            if (c == rst_at) begin
                hist.delete();
                aborted = 1'b1;
            end else begin
                s.a = hs_exp ? a_vec : '0;
                s.b = hs_exp ? b_vec : '0;
                hist.push_back(s);
                if (hist.size() > N) void'(hist.pop_front());
            end
            if (hs_exp) begin
                beats++;
                if (beats == kb) last = c;
            end
            if ((last >= 0 && !aborted && c == last + 3 * N + 2) ||
                (aborted && c == rst_at + 4)) begin
                finished = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        start = 0; valid = 0; rst = 0;
        n_cmp++;
        if (!finished) begin
            n_bad++; $display("FAIL %s timeout got running want finished", tag);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            rst = 1; start = 1'($urandom); valid = 1'($urandom); k = KW'($urandom);
            a_vec = N*W'($urandom); b_vec = N*W'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({ready, busy, send, done, a_edge, b_edge} !== '0) begin
                n_bad++;
                $display("FAIL reset cycle %0d got r%b b%b s%b d%b a=%h b=%h want all 0",
                         i, ready, busy, send, done, a_edge, b_edge);
            end
        end
        @(posedge clk);
        #1;
        rst = 0; start = 0; valid = 0;
    endtask

    task automatic test_single_beat();
        for (int r = 0; r < N; r++) begin
            beat_a[0][r] = W'(r + 1);
            beat_b[0][r] = W'(r + 5);
        end
        run_tile("single_beat", 1, 32'h0, -1, -1);
    endtask

    task automatic test_bubble();
        fill_random();
        run_tile("bubble", 3, 32'h4, -1, -1);
    endtask

    task automatic test_restart_ignored();
        fill_random();
        run_tile("restart", 4, 32'h0, 2, -1);
    endtask

    task automatic test_k_zero();
        @(posedge clk);
        #1;
        start = 1; k = '0; valid = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ready, busy, send, done} !== 4'b0) begin
                n_bad++;
                $display("FAIL k_zero cycle %0d got r%b b%b s%b d%b want 0000",
                         i, ready, busy, send, done);
            end
            @(posedge clk);
            #1;
            start = 0;
        end
        valid = 0;
    endtask

    task automatic test_reset_mid();
        fill_random();
        run_tile("reset_mid", 4, 32'h0, -1, 3);
    endtask

    task automatic test_array();
        for (int i = 0; i < N; i++)
            for (int r = 0; r < N; r++) begin
                beat_a[i][r] = (r == i) ? W'(1) : W'(0);
                beat_b[i][r] = W'(i * N + r + 1);
            end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                acc[r][c] = 0; ap[r][c] = 0; bp[r][c] = 0; drained[r][c] = -1;
            end
        n_drained = 0;
        run_tile("array", N, 32'h0, -1, -1);
        n_cmp++;
        if (n_drained != N) begin
            n_bad++; $display("FAIL array drain_cycles got %0d want %0d", n_drained, N);
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                n_cmp += 2;
                if (drained[r][c] != r * N + c + 1) begin
                    n_bad++;
                    $display("FAIL array C[%0d][%0d] got %0d want %0d", r, c, drained[r][c],
                             r * N + c + 1);
                end
                if (acc[r][c] != 0) begin
                    n_bad++;
                    $display("FAIL array acc[%0d][%0d] got %0d want 0", r, c, acc[r][c]);
                end
            end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_bubble();
        test_restart_ignored();
        test_k_zero();
        test_reset_mid();
        test_array();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
